// File: rtl/ula_operand_fetch_pkg.sv
// Shared constants and types for the ULA operand-fetch stage.
package ula_operand_fetch_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;

  // Supported primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;

  // R-type function codes understood by the ULA.
  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_AND   = 2'd1,
    ALUOP_RTYPE = 2'd2
  } alu_op_e;

  // Shifts take their operand from rt and shift it by shamt.
  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/ula_reg_file.sv
// 32-entry architectural register file: two async read ports with
// write-through bypass, one sync write port, sync active-low clear.
module ula_reg_file
  import ula_operand_fetch_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int NR  = REG_COUNT,
  parameter int AW  = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] regs_q [NR];
  logic          wr_live;

  assign wr_live = we_i && (waddr_i != '0);

  // Register storage: cleared on reset, written on nonzero-index strobe.
  // NOTE: this array is architecturally required to read 0 after reset, so
  // every entry is cleared here; a plain RAM would normally not be reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      // NOTE: state is updated with <= so all flops sample pre-edge values.
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A: R0 is hardwired zero, same-cycle writes are forwarded.
  always_comb begin
    if (raddr_a_i == '0)                        rdata_a_o = '0;
    else if (wr_live && waddr_i == raddr_a_i)   rdata_a_o = wdata_i;
    else                                        rdata_a_o = regs_q[raddr_a_i];
  end

  // Read port B: same rules as port A.
  always_comb begin
    if (raddr_b_i == '0)                        rdata_b_o = '0;
    else if (wr_live && waddr_i == raddr_b_i)   rdata_b_o = wdata_i;
    else                                        rdata_b_o = regs_q[raddr_b_i];
  end

endmodule

// File: rtl/ula_operand_fetch.sv
// Decode/operand stage in front of the ULA: decodes one instruction per
// handshake, reads operands, and registers the op with 1-cycle latency.
module ula_operand_fetch
  import ula_operand_fetch_pkg::*;
#(
  parameter int DATA_W_P    = DATA_W,
  parameter int REG_COUNT_P = REG_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [31:0]       instr,
  input  logic              wbEnable,
  input  logic [4:0]        wbAddr,
  input  logic [DATA_W_P-1:0] wbData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W_P-1:0] input1,
  output logic [DATA_W_P-1:0] input2,
  output logic [4:0]        shamt,
  output logic [1:0]        aluOp,
  output logic [5:0]        funct,
  output logic [5:0]        opCode,
  output logic [4:0]        destReg,
  output logic              illegal
);

  logic [5:0]  f_op, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm;
  logic [DATA_W_P-1:0] rs_val, rt_val;

  assign f_op    = instr[31:26];
  assign f_rs    = instr[25:21];
  assign f_rt    = instr[20:16];
  assign f_rd    = instr[15:11];
  assign f_shamt = instr[10:6];
  assign f_funct = instr[5:0];
  assign f_imm   = instr[15:0];

  ula_reg_file #(.DW(DATA_W_P), .NR(REG_COUNT_P), .AW(5)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wbEnable),
    .waddr_i   (wbAddr),
    .wdata_i   (wbData),
    .raddr_a_i (f_rs),
    .raddr_b_i (f_rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  // Decoded next-state for the output register.
  logic [DATA_W_P-1:0] in1_d, in2_d;
  alu_op_e             op_d;
  logic [4:0]          dest_d;
  logic                illegal_d;

  // Opcode decode and operand selection.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    in1_d     = '0;
    in2_d     = '0;
    op_d      = ALUOP_ADD;
    dest_d    = '0;
    illegal_d = 1'b0;
    case (f_op)
      OP_RTYPE: begin
        op_d   = ALUOP_RTYPE;
        dest_d = f_rd;
        if (is_shift(f_funct)) begin
          in1_d = rt_val;
        end else begin
          in1_d = rs_val;
          in2_d = rt_val;
        end
      end
      OP_ADDI: begin
        in1_d  = rs_val;
        in2_d  = {{(DATA_W_P-16){f_imm[15]}}, f_imm};
        dest_d = f_rt;
      end
      OP_ANDI: begin
        op_d   = ALUOP_AND;
        in1_d  = rs_val;
        in2_d  = {{(DATA_W_P-16){1'b0}}, f_imm};
        dest_d = f_rt;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic                valid_q;
  logic [DATA_W_P-1:0] in1_q, in2_q;
  logic [4:0]          shamt_q, dest_q;
  alu_op_e             op_q;
  logic [5:0]          funct_q, opcode_q;
  logic                illegal_q;
  logic                accept;

  assign instrReady = !valid_q || outReady;
  assign accept     = instrValid && instrReady;

  // Output register: load on accept, drop valid when drained, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      shamt_q   <= '0;
      op_q      <= ALUOP_ADD;
      funct_q   <= '0;
      opcode_q  <= '0;
      dest_q    <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      shamt_q   <= f_shamt;
      op_q      <= op_d;
      funct_q   <= f_funct;
      opcode_q  <= f_op;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
    end else if (outReady) begin
      valid_q   <= 1'b0;
    end
  end

  assign outValid = valid_q;
  assign input1   = in1_q;
  assign input2   = in2_q;
  assign shamt    = shamt_q;
  assign aluOp    = op_q;
  assign funct    = funct_q;
  assign opCode   = opcode_q;
  assign destReg  = dest_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_ula_operand_fetch.sv
// Self-checking bench for ula_operand_fetch: behavioural model compared
// every cycle plus hand-computed literal checkpoints.
module tb_ula_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instrValid, instrReady;
  logic [31:0] instr;
  logic        wbEnable;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        outValid, outReady;
  logic [31:0] input1, input2;
  logic [4:0]  shamt, destReg;
  logic [1:0]  aluOp;
  logic [5:0]  funct, opCode;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ula_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
    .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
    .outValid(outValid), .outReady(outReady),
    .input1(input1), .input2(input2), .shamt(shamt), .aluOp(aluOp),
    .funct(funct), .opCode(opCode), .destReg(destReg), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_r [32];
  bit          m_started = 0;
  bit          m_valid;
  logic [31:0] e_in1, e_in2;
  logic [4:0]  e_shamt, e_dest;
  logic [1:0]  e_op;
  logic [5:0]  e_funct, e_opc;
  logic        e_ill;

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wbEnable && wbAddr == a) return wbData;
    return m_r[a];
  endfunction

  task automatic model_decode(input logic [31:0] w);
    int opc, fn;
    logic [4:0] rs, rt, rd;
    opc = int'(w >> 26);
    fn  = int'(w & 32'h3F);
    rs  = 5'((w >> 21) & 32'h1F);
    rt  = 5'((w >> 16) & 32'h1F);
    rd  = 5'((w >> 11) & 32'h1F);
    e_shamt = 5'((w >> 6) & 32'h1F);
    e_funct = 6'(fn);
    e_opc   = 6'(opc);
    e_in1 = 0; e_in2 = 0; e_dest = 0; e_op = 0; e_ill = 0;
    if (opc == 0) begin
      e_op = 2; e_dest = rd;
      if (fn == 0 || fn == 2 || fn == 3) e_in1 = mread(rt);
      else begin e_in1 = mread(rs); e_in2 = mread(rt); end
    end else if (opc == 8) begin
      e_in1 = mread(rs); e_dest = rt;
      e_in2 = (w[15]) ? (32'hFFFF0000 | (w & 32'hFFFF)) : (w & 32'hFFFF);
    end else if (opc == 12) begin
      e_op = 1; e_in1 = mread(rs); e_dest = rt;
      e_in2 = w & 32'hFFFF;
    end else begin
      e_ill = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 1;
      m_valid = 0;
      e_in1 = 0; e_in2 = 0; e_shamt = 0; e_dest = 0; e_op = 0;
      e_funct = 0; e_opc = 0; e_ill = 0;
      for (int i = 0; i < 32; i++) m_r[i] = 0;
    end else begin
      if (instrValid && (!m_valid || outReady)) begin
        model_decode(instr);
        m_valid = 1;
      end else if (outReady) begin
        m_valid = 0;
      end
      if (wbEnable && wbAddr != 0) m_r[wbAddr] = wbData;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("m_outValid",   {31'd0, outValid},   {31'd0, m_valid});
      check("m_instrReady", {31'd0, instrReady}, {31'd0, (!m_valid || outReady)});
      check("m_input1",  input1, e_in1);
      check("m_input2",  input2, e_in2);
      check("m_shamt",   {27'd0, shamt},   {27'd0, e_shamt});
      check("m_aluOp",   {30'd0, aluOp},   {30'd0, e_op});
      check("m_funct",   {26'd0, funct},   {26'd0, e_funct});
      check("m_opCode",  {26'd0, opCode},  {26'd0, e_opc});
      check("m_destReg", {27'd0, destReg}, {27'd0, e_dest});
      check("m_illegal", {31'd0, illegal}, {31'd0, e_ill});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting cycle, then idle.
  task automatic issue(input logic [31:0] w);
    instr = w; instrValid = 1'b1;
    tick();
    instrValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instrValid = 1'b0; instr = '0; outReady = 1'b1;
    wbEnable = 1'b0; wbAddr = '0; wbData = '0;
    tick(); tick();
    check("rst_outValid", {31'd0, outValid}, 32'd0);
    check("rst_input1",   input1, 32'd0);
    rst_n = 1'b1;

    wbEnable = 1'b1; wbAddr = 5'd1; wbData = 32'd5;          tick();
    wbAddr = 5'd2; wbData = 32'hFFFF_FFFD;                    tick();
    wbEnable = 1'b0;

    // add $3,$1,$2
    instr = 32'h0022_1820; instrValid = 1'b1;
    check("pre_accept_outValid", {31'd0, outValid}, 32'd0);
    tick(); instrValid = 1'b0;
    check("add_outValid", {31'd0, outValid}, 32'd1);
    check("add_input1",   input1, 32'd5);
    check("add_input2",   input2, 32'hFFFF_FFFD);
    check("add_aluOp",    {30'd0, aluOp}, 32'd2);
    check("add_funct",    {26'd0, funct}, 32'd32);
    check("add_destReg",  {27'd0, destReg}, 32'd3);

    // addi $4,$1,-1
    issue(32'h2024_FFFF);
    check("addi_input2",  input2, 32'hFFFF_FFFF);
    check("addi_aluOp",   {30'd0, aluOp}, 32'd0);
    check("addi_destReg", {27'd0, destReg}, 32'd4);

    // andi $6,$1,0x8001
    issue(32'h3026_8001);
    check("andi_input2",  input2, 32'h0000_8001);
    check("andi_aluOp",   {30'd0, aluOp}, 32'd1);

    // sll $5,$2,4 -- leave valid so the next op replaces it back-to-back
    issue(32'h0002_2900);
    check("sll_input1",   input1, 32'hFFFF_FFFD);
    check("sll_shamt",    {27'd0, shamt}, 32'd4);
    check("sll_funct",    {26'd0, funct}, 32'd0);
    check("sll_destReg",  {27'd0, destReg}, 32'd5);

    // sub $7,$1,$2 accepted while sll still valid (full throughput)
    issue(32'h0022_3822);
    check("sub_destReg",  {27'd0, destReg}, 32'd7);

    // Stall: or $8,$1,$2 waits 3 cycles behind outReady=0
    outReady = 1'b0; instr = 32'h0022_4025; instrValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instrReady", {31'd0, instrReady}, 32'd0);
      check("stall_funct",      {26'd0, funct}, 32'd34);
      check("stall_destReg",    {27'd0, destReg}, 32'd7);
    end
    outReady = 1'b1;
    tick(); instrValid = 1'b0;
    check("or_funct",   {26'd0, funct}, 32'd37);
    check("or_destReg", {27'd0, destReg}, 32'd8);

    // Bypass: write R1=7 while addi $9,$1,2 is accepted
    wbEnable = 1'b1; wbAddr = 5'd1; wbData = 32'd7;
    issue(32'h2029_0002);
    check("bypass_input1", input1, 32'd7);

    // Write to R0 is ignored; addi $10,$0,0 in the same cycle reads 0
    wbAddr = 5'd0; wbData = 32'd99;
    issue(32'h200A_0000);
    wbEnable = 1'b0;
    check("r0_bypass_input1", input1, 32'd0);
    issue(32'h0001_5820);  // add $11,$0,$1
    check("r0_input1", input1, 32'd0);
    check("r1_input2", input2, 32'd7);

    // Unsupported opcode 0x23
    issue(32'h8C22_0000);
    check("ill_illegal", {31'd0, illegal}, 32'd1);
    check("ill_outValid", {31'd0, outValid}, 32'd1);
    check("ill_opCode",  {26'd0, opCode}, 32'h23);
    check("ill_input1",  input1, 32'd0);

    // Drain: valid drops, data holds
    tick();
    check("drain_outValid", {31'd0, outValid}, 32'd0);
    check("drain_opCode",   {26'd0, opCode}, 32'h23);

    // Reset while valid, with a competing write-back (reset wins)
    outReady = 1'b0;
    issue(32'h0022_1820);
    rst_n = 1'b0; wbEnable = 1'b1; wbAddr = 5'd1; wbData = 32'd55;
    tick();
    check("rst2_outValid", {31'd0, outValid}, 32'd0);
    rst_n = 1'b1; wbEnable = 1'b0; outReady = 1'b1;
    issue(32'h0020_1820);  // add $3,$1,$0
    check("rst2_R1", input1, 32'd0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
